// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-port (fetch / load-store) arbiter onto one shared word RAM.
//            Fixed lsu-over-fetch priority by default; define RAM_ARB_RR_EN
//            for round-robin on simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,

    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_sel_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,

    output logic                    ram_ce_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_sel_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int c_SEL_W = DATA_WIDTH / 8;

    logic                  r_last_lsu;
    logic                  r_if_rvalid;
    logic                  r_lsu_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_lsu_rdata;

    logic                  w_lsu_wins;
    logic                  w_gnt_if;
    logic                  w_gnt_lsu;

`ifdef RAM_ARB_RR_EN
    // On contention, hand the RAM to whichever port did not get it last time.
    assign w_lsu_wins = ~r_last_lsu;
`else
    assign w_lsu_wins = 1'b1 | r_last_lsu;
`endif

    assign w_gnt_lsu = ~rst & lsu_req_i & (~if_req_i | w_lsu_wins);
    assign w_gnt_if  = ~rst & if_req_i & ~w_gnt_lsu;

    assign if_gnt_o  = w_gnt_if;
    assign lsu_gnt_o = w_gnt_lsu;

    always_comb begin
        ram_ce_o    = w_gnt_if | w_gnt_lsu;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_sel_o   = '0;
        if (w_gnt_lsu) begin
            ram_we_o    = lsu_we_i;
            ram_addr_o  = lsu_addr_i;
            ram_wdata_o = lsu_wdata_i;
            ram_sel_o   = lsu_sel_i;
        end else if (w_gnt_if) begin
            ram_addr_o  = if_addr_i;
            ram_sel_o   = {c_SEL_W{1'b1}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_lsu   <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_lsu_rdata  <= '0;
        end else begin
            r_if_rvalid  <= w_gnt_if;
            r_lsu_rvalid <= w_gnt_lsu;
            if (w_gnt_if | w_gnt_lsu) begin
                r_last_lsu <= w_gnt_lsu;
            end
            if (w_gnt_if) begin
                r_if_rdata <= ram_rdata_i;
            end
            if (w_gnt_lsu) begin
                r_lsu_rdata <= lsu_we_i ? '0 : ram_rdata_i;
            end
        end
    end

    // A response captured just before reset rises must not be seen while reset is held.
    assign if_rvalid_o  = r_if_rvalid & ~rst;
    assign lsu_rvalid_o = r_lsu_rvalid & ~rst;
    assign if_rdata_o   = r_if_rdata;
    assign lsu_rdata_o  = r_lsu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Self-checking bench for ram_arbiter against a transaction-level
//            model (arbitration rule, reference memory, expected responses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [3:0]    lsu_sel;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [3:0]    ram_sel;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .lsu_req_i    (lsu_req),
        .lsu_we_i     (lsu_we),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_sel_i    (lsu_sel),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .ram_ce_o     (ram_ce),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_sel_o    (ram_sel),
        .ram_rdata_i  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: 16 words, byte-masked write, combinational read.
    logic [DW-1:0] ram_mem [16];
    assign ram_rdata = ram_mem[ram_addr[5:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [16];
    logic          m_last_lsu;
    logic          exp_if_v, exp_lsu_v;
    logic [DW-1:0] exp_if_d, exp_lsu_d;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic ifr, input logic [31:0] ifa,
                        input logic lr, input logic lwe, input logic [31:0] la,
                        input logic [31:0] lwd, input logic [3:0] ls,
                        output logic g_if, output logic g_lsu);
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        check("if_rvalid",  if_rvalid,  exp_if_v);
        check("if_rdata",   if_rdata,   exp_if_d);
        check("lsu_rvalid", lsu_rvalid, exp_lsu_v);
        check("lsu_rdata",  lsu_rdata,  exp_lsu_d);

        if_req = ifr; if_addr = ifa;
        lsu_req = lr; lsu_we = lwe; lsu_addr = la; lsu_wdata = lwd; lsu_sel = ls;
        #1;
`ifdef RAM_ARB_RR_EN
        g_lsu = lr && (!ifr || !m_last_lsu);
`else
        g_lsu = lr;
`endif
        g_if = ifr && !g_lsu;
        e_addr  = g_lsu ? la : (g_if ? ifa : 32'h0);
        e_wdata = g_lsu ? lwd : 32'h0;
        e_sel   = g_lsu ? ls : (g_if ? 4'hF : 4'h0);
        check("if_gnt",    if_gnt,    g_if);
        check("lsu_gnt",   lsu_gnt,   g_lsu);
        check("ram_ce",    ram_ce,    g_if || g_lsu);
        check("ram_we",    ram_we,    g_lsu && lwe);
        check("ram_addr",  ram_addr,  e_addr);
        check("ram_wdata", ram_wdata, e_wdata);
        check("ram_sel",   ram_sel,   e_sel);

        exp_if_v  = g_if;
        exp_lsu_v = g_lsu;
        if (g_if) exp_if_d = ref_mem[ifa[5:2]];
        if (g_lsu) begin
            if (lwe) begin
                exp_lsu_d = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (ls[b]) ref_mem[la[5:2]][8*b +: 8] = lwd[8*b +: 8];
            end else begin
                exp_lsu_d = ref_mem[la[5:2]];
            end
        end
        if (g_if || g_lsu) m_last_lsu = g_lsu;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic ifr, input logic lr);
        rst = 1'b1;
        if_req = ifr; if_addr = 32'h4;
        lsu_req = lr; lsu_we = 1'b0; lsu_addr = 32'h8; lsu_wdata = 32'h0; lsu_sel = 4'h0;
        #1;
        check("rst_if_gnt",     if_gnt,     1'b0);
        check("rst_lsu_gnt",    lsu_gnt,    1'b0);
        check("rst_ram_ce",     ram_ce,     1'b0);
        check("rst_if_rvalid",  if_rvalid,  1'b0);
        check("rst_lsu_rvalid", lsu_rvalid, 1'b0);
        exp_if_v = 1'b0; exp_lsu_v = 1'b0;
        exp_if_d = '0;   exp_lsu_d = '0;
        m_last_lsu = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic        gi, gl;
    logic        p_if, p_lsu;
    logic        r_ifr, r_lr, r_lwe;
    logic [31:0] r_ifa, r_la, r_lwd;
    logic [3:0]  r_ls;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_mem[2] = 32'hDEADBEEF;
        ref_mem[2] = 32'hDEADBEEF;
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset(1'b1, 1'b1);

        // Fetch-only read of word 2
        step(1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);
        check("fetch_deadbeef", if_rdata, 32'hDEADBEEF);

        // Masked store then load of the same word
        step(0, 32'h0, 1, 1, 32'h10, 32'h11223344, 4'b0101, gi, gl);
        step(0, 32'h0, 1, 0, 32'h10, 32'h0, 4'h0, gi, gl);
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);
        check("store_load_word", lsu_rdata, 32'h00220044);

        // Sustained contention, then fetch alone
        for (int i = 0; i < 3; i++)
            step(1, 32'h20, 1, 0, 32'h8, 32'h0, 4'h0, gi, gl);
        step(1, 32'h20, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);

        // Contention straight out of reset
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1, 32'h8, 1, 0, 32'h10, 32'h0, 4'h0, gi, gl);
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);

        // Reset landing right after a fetch grant
        step(1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);
        do_reset(1'b1, 1'b0);
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);

        // Randomized traffic; an ungranted request holds its payload
        p_if = 1'b0; p_lsu = 1'b0;
        r_ifr = 0; r_lr = 0; r_lwe = 0; r_ifa = 0; r_la = 0; r_lwd = 0; r_ls = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                p_if = 1'b0; p_lsu = 1'b0;
            end
            if (!p_if) begin
                r_ifr = ($urandom_range(0, 3) != 0);
                r_ifa = $urandom();
            end
            if (!p_lsu) begin
                r_lr  = ($urandom_range(0, 2) != 0);
                r_lwe = $urandom_range(0, 1) == 1;
                r_la  = $urandom();
                r_lwd = $urandom();
                r_ls  = 4'($urandom_range(0, 15));
            end
            step(r_ifr, r_ifa, r_lr, r_lwe, r_la, r_lwd, r_ls, gi, gl);
            p_if  = r_ifr && !gi;
            p_lsu = r_lr && !gl;
        end
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, gi, gl);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port if_req_i  input  1  fetch port read request.
REQ-006 SHALL have port if_addr_i  input  ADDR_WIDTH  fetch byte address.
REQ-007 SHALL have port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid_o  output  1  fetch read data valid.
REQ-009 SHALL have port if_rdata_o  output  DATA_WIDTH  fetch read data.
REQ-010 SHALL have port lsu_req_i  input  1  load/store port request.
REQ-011 SHALL have port lsu_we_i  input  1  load/store write enable.
REQ-012 SHALL have port lsu_addr_i  input  ADDR_WIDTH  load/store byte address.
REQ-013 SHALL have port lsu_wdata_i  input  DATA_WIDTH  store data.
REQ-014 SHALL have port lsu_sel_i  input  DATA_WIDTH/8  store byte enables.
REQ-015 SHALL have port lsu_gnt_o  output  1  load/store request accepted this cycle.
REQ-016 SHALL have port lsu_rvalid_o  output  1  load data valid / store acknowledge.
REQ-017 SHALL have port lsu_rdata_o  output  DATA_WIDTH  load data.
REQ-018 SHALL have ports ram_ce_o, ram_we_o (1), ram_addr_o (ADDR_WIDTH), ram_wdata_o (DATA_WIDTH), ram_sel_o (DATA_WIDTH/8), all outputs driving the shared word RAM.
REQ-019 SHALL have port ram_rdata_i  input  DATA_WIDTH  combinational RAM read data.

Function
REQ-020 SHALL grant at most one port per cycle; if_gnt_o & lsu_gnt_o never both 1.
REQ-021 SHALL compute gnt combinationally from req in the same cycle; a sole requester is always granted.
REQ-022 SHALL drive RAM from granted port in the grant cycle: ram_ce_o=1; fetch: we=0, sel=all ones; lsu: we/addr/wdata/sel passed through.
REQ-023 SHALL drive ram_ce_o=0, ram_we_o=0, ram_sel_o=0, addr/wdata=0 when no grant.
REQ-024 SHALL register ram_rdata_i at the grant-cycle edge; granted port's rvalid_o is 1 for exactly the following cycle, with rdata_o holding the captured word.
REQ-025 SHALL, for a granted store, pulse lsu_rvalid_o next cycle with lsu_rdata_o=0.
REQ-026 SHALL hold rdata_o at last captured value while rvalid_o=0.
REQ-027 SHALL support back-to-back grants every cycle (throughput 1 access/cycle, latency 1 cycle).
REQ-028 Requesters SHALL hold req and payload stable until gnt; ungranted req is never dropped by arbiter.
REQ-029 SHALL arbitrate by fixed priority, lsu over fetch, when RAM_ARB_RR_EN undefined.
REQ-030 SHALL track last-granted port in a 1-bit register last_lsu (reset 0), updated on every grant.
REQ-031 SHALL pass address through unmodified; word alignment is the RAM's job.

Reset
REQ-032 SHALL on rst force if_rvalid_o=0, lsu_rvalid_o=0, if_rdata_o=0, lsu_rdata_o=0, last_lsu=0.
REQ-033 SHALL suppress all grants and RAM enables (ram_ce_o=0) while rst=1.
REQ-034 SHALL discard a response pending across a reset edge; no rvalid after rst deasserts.

Configuration
REQ-035 SHALL, with RAM_ARB_RR_EN defined, arbitrate round-robin on simultaneous requests: grant the port not granted last (last_lsu=1 -> fetch, else lsu).
REQ-036 SHALL, without RAM_ARB_RR_EN, use fixed lsu priority (REQ-029); last_lsu still maintained.

Verification
REQ-037 Fetch only: if_req=1, addr=0x8, mem[2]=0xDEADBEEF -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0xDEADBEEF.
REQ-038 Store then load: lsu we=1, addr=0x10, wdata=0x11223344, sel=4'b0101; next load 0x10, old word 0 -> lsu_rdata=0x00220044 after rvalid.
REQ-039 Contention, no macro: both req 3 cycles -> lsu granted 3 cycles, fetch 0; fetch granted cycle 4 after lsu drops.
REQ-040 Contention, RAM_ARB_RR_EN: both req 4 cycles from reset -> grants lsu, fetch, lsu, fetch; one rvalid per grant, next cycle, correct port.
REQ-041 Reset mid-op: grant fetch, assert rst next edge -> if_rvalid=0, ram_ce_o=0 throughout rst; no stray rvalid after release.
